imem_loader: RTL and testbench

UART bootloader that writes the instruction memory. It receives a length-prefixed, checksummed byte stream on a serial line and writes each payload byte to consecutive byte addresses starting at 0. The RV32I core is held in reset until a complete image has been received and verified. It sits between the board UART pin and the write port of the instruction memory. The core's fetch side stays read-only.

---
 rtl/imem_loader.sv | 262 ++++++++++++++++++++++++++
 tb/tb_imem_loader.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader -- UART bootloader for the RV32I instruction memory.
//
// Receives a frame of LEN_LO, LEN_HI, N payload bytes and an XOR checksum
// on an 8N1 serial line. Each payload byte is written to consecutive byte
// addresses starting at 0. The core is held in reset until a complete
// frame with a matching checksum has been received.
//
// Ports:
//   clk         system clock
//   reset       synchronous, active-high reset
//   uart_rx     asynchronous serial input, idle high
//   wr_en       one-cycle write strobe to the instruction memory
//   wr_addr     byte address of wr_data
//   wr_data     payload byte
//   core_reset  high holds the core in reset; low only after a verified load
//   load_done   high once the image is verified; stays high until reset
//   frame_err   sticky, bad stop bit; cleared at the start of the next header
//   len_err     sticky, length > MEM_BYTES; cleared at the next header
//   csum_err    sticky, checksum mismatch; cleared at the next header
module imem_loader #(
  parameter int CLKS_PER_BIT = 868,
  parameter int MEM_BYTES    = 2048,
  parameter int ADDR_W       = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              uart_rx,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              core_reset,
  output logic              load_done,
  output logic              frame_err,
  output logic              len_err,
  output logic              csum_err
);

  localparam int          CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
  localparam int unsigned MEM_LIMIT = MEM_BYTES;

  // ---------------------------------------------------------------------
  // Input synchronizer; reset to the idle level so reset never looks like
  // a start bit.
  // ---------------------------------------------------------------------
  logic rx_meta_q, rx_sync_q;

  // NOTE: clocked state is always assigned with <= so every flop samples the
  // pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= uart_rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  // ---------------------------------------------------------------------
  // RX state machine
  // ---------------------------------------------------------------------
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  rx_state_e        rx_state_q, rx_state_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]       rx_bit_q, rx_bit_d;
  logic [7:0]       rx_shift_q, rx_shift_d;
  logic             byte_valid;
  logic             stop_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    unique case (rx_state_q)
      RX_IDLE: begin
        if (!rx_sync_q) begin
          rx_state_d = RX_START;
          rx_cnt_d   = '0;
        end
      end
      RX_START: begin
        // Mid-start-bit check rejects glitches shorter than half a bit.
        if (rx_cnt_q == HALF_M1) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == FULL_M1) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 1'b1;
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == FULL_M1) begin
          rx_cnt_d   = '0;
          rx_state_d = RX_IDLE;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_comb begin
    byte_valid = (rx_state_q == RX_STOP) && (rx_cnt_q == FULL_M1) &&  rx_sync_q;
    stop_err   = (rx_state_q == RX_STOP) && (rx_cnt_q == FULL_M1) && !rx_sync_q;
  end

  // ---------------------------------------------------------------------
  // Load state machine
  // ---------------------------------------------------------------------
  typedef enum logic [2:0] {S_HDR0, S_HDR1, S_DATA, S_CSUM, S_DONE} ld_state_e;

  ld_state_e         ld_state_q, ld_state_d;
  logic [7:0]        len_lo_q, len_lo_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        xor_q, xor_d;
  logic              frame_err_q, frame_err_d;
  logic              len_err_q, len_err_d;
  logic              csum_err_q, csum_err_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic [15:0]       hdr_len;
  logic              last_byte;

  always_ff @(posedge clk) begin
    if (reset) begin
      ld_state_q  <= S_HDR0;
      len_lo_q    <= '0;
      len_q       <= '0;
      addr_q      <= '0;
      xor_q       <= '0;
      frame_err_q <= 1'b0;
      len_err_q   <= 1'b0;
      csum_err_q  <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
    end else begin
      ld_state_q  <= ld_state_d;
      len_lo_q    <= len_lo_d;
      len_q       <= len_d;
      addr_q      <= addr_d;
      xor_q       <= xor_d;
      frame_err_q <= frame_err_d;
      len_err_q   <= len_err_d;
      csum_err_q  <= csum_err_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
    end
  end

  // Byte count compared one bit wider than addr so N = MEM_BYTES terminates
  // on the final byte even though addr itself would roll over.
  assign hdr_len   = {rx_shift_q, len_lo_q};
  assign last_byte = ({1'b0, addr_q} + (ADDR_W + 1)'(1)) == len_q;

  always_comb begin
    ld_state_d  = ld_state_q;
    len_lo_d    = len_lo_q;
    len_d       = len_q;
    addr_d      = addr_q;
    xor_d       = xor_q;
    frame_err_d = frame_err_q;
    len_err_d   = len_err_q;
    csum_err_d  = csum_err_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;

    if (ld_state_q != S_DONE && stop_err) begin
      // A framing error anywhere before completion abandons the frame.
      frame_err_d = 1'b1;
      ld_state_d  = S_HDR0;
    end else if (byte_valid) begin
      unique case (ld_state_q)
        S_HDR0: begin
          len_lo_d    = rx_shift_q;
          frame_err_d = 1'b0;
          len_err_d   = 1'b0;
          csum_err_d  = 1'b0;
          ld_state_d  = S_HDR1;
        end
        S_HDR1: begin
          if (32'(hdr_len) > MEM_LIMIT) begin
            len_err_d  = 1'b1;
            ld_state_d = S_HDR0;
          end else begin
            // Accumulator is cleared for empty images too, so a stale value
            // from an aborted frame cannot leak into the checksum.
            len_d      = hdr_len[ADDR_W:0];
            addr_d     = '0;
            xor_d      = '0;
            ld_state_d = (hdr_len == 16'd0) ? S_CSUM : S_DATA;
          end
        end
        S_DATA: begin
          wr_en_d   = 1'b1;
          wr_addr_d = addr_q;
          wr_data_d = rx_shift_q;
          xor_d     = xor_q ^ rx_shift_q;
          addr_d    = addr_q + ADDR_W'(1);
          if (last_byte) ld_state_d = S_CSUM;
        end
        S_CSUM: begin
          if (rx_shift_q == xor_q) begin
            ld_state_d = S_DONE;
          end else begin
            csum_err_d = 1'b1;
            ld_state_d = S_HDR0;
          end
        end
        S_DONE:  ld_state_d = S_DONE;
        default: ld_state_d = S_HDR0;
      endcase
    end
  end

  always_comb begin
    core_reset = (ld_state_q != S_DONE);
    load_done  = (ld_state_q == S_DONE);
    wr_en      = wr_en_q;
    wr_addr    = wr_addr_q;
    wr_data    = wr_data_q;
    frame_err  = frame_err_q;
    len_err    = len_err_q;
    csum_err   = csum_err_q;
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed testbench for imem_loader with CLKS_PER_BIT = 16.
module tb_imem_loader;

  localparam int CPB    = 16;
  localparam int ADDR_W = 11;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              uart_rx = 1'b1;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              core_reset, load_done, frame_err, len_err, csum_err;

  int vectors = 0;
  int errors  = 0;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
  } wr_t;
  typedef logic [7:0] bq_t[$];

  wr_t wr_log[$];

  imem_loader #(.CLKS_PER_BIT(CPB), .MEM_BYTES(2048), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .uart_rx(uart_rx),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .core_reset(core_reset), .load_done(load_done),
    .frame_err(frame_err), .len_err(len_err), .csum_err(csum_err)
  );

  always #5 clk = ~clk;

  // Every cycle wr_en is seen high becomes one log entry, so a stretched
  // strobe shows up as an extra write.
  always @(negedge clk) if (wr_en === 1'b1) wr_log.push_back({wr_addr, wr_data});

  task automatic apply_reset();
    reset = 1'b1;
    uart_rx = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    wr_log.delete();
  endtask

  task automatic drive_bit(input logic v);
    uart_rx = v;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_bit);
    uart_rx = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic send_bytes(input bq_t bs);
    foreach (bs[i]) send_byte(bs[i], 1'b1);
  endtask

  task automatic check_writes(input string tag, input bq_t exp, input int base);
    vectors++;
    if (wr_log.size() !== exp.size()) begin
      errors++;
      $display("FAIL %s_write_count got=%0d exp=%0d", tag, wr_log.size(), exp.size());
    end else begin
      for (int i = 0; i < exp.size(); i++) begin
        vectors++;
        if (wr_log[i] !== {ADDR_W'(base + i), exp[i]}) begin
          errors++;
          $display("FAIL %s_write%0d got=%h/%h exp=%h/%h", tag, i,
                   wr_log[i].addr, wr_log[i].data, ADDR_W'(base + i), exp[i]);
        end
      end
    end
  endtask

  task automatic check_flags(input string tag, input logic [4:0] exp);
    @(negedge clk);
    vectors++;
    if ({core_reset, load_done, frame_err, len_err, csum_err} !== exp) begin
      errors++;
      $display("FAIL %s_flags {core_reset,load_done,frame,len,csum} got=%b exp=%b",
               tag, {core_reset, load_done, frame_err, len_err, csum_err}, exp);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    vectors++;
    if ({wr_en, wr_addr, wr_data} !== '0) begin
      errors++;
      $display("FAIL reset_wr got=%b/%h/%h exp=0/0/0", wr_en, wr_addr, wr_data);
    end
    check_flags("reset", 5'b10000);
  endtask

  task automatic test_good_load();
    apply_reset();
    send_bytes('{8'h04, 8'h00, 8'h13, 8'h02, 8'h80, 8'h02, 8'h93});
    check_writes("good", '{8'h13, 8'h02, 8'h80, 8'h02}, 0);
    check_flags("good", 5'b01000);
  endtask

  task automatic test_csum_mismatch();
    apply_reset();
    send_bytes('{8'h04, 8'h00, 8'h13, 8'h02, 8'h80, 8'h02, 8'h00});
    check_writes("csum_bad", '{8'h13, 8'h02, 8'h80, 8'h02}, 0);
    check_flags("csum_bad", 5'b10001);
    send_byte(8'h04, 1'b1);
    check_flags("csum_clear", 5'b10000);
    wr_log.delete();
    send_bytes('{8'h00, 8'h13, 8'h02, 8'h80, 8'h02, 8'h93});
    check_writes("csum_retry", '{8'h13, 8'h02, 8'h80, 8'h02}, 0);
    check_flags("csum_retry", 5'b01000);
  endtask

  task automatic test_length_limits();
    apply_reset();
    send_bytes('{8'h01, 8'h08});
    check_writes("len_over", '{}, 0);
    check_flags("len_over", 5'b10010);
    send_bytes('{8'h00, 8'h00, 8'h00});
    check_writes("len_zero", '{}, 0);
    check_flags("len_zero", 5'b01000);
    // Exactly MEM_BYTES is legal and starts writing.
    apply_reset();
    send_bytes('{8'h00, 8'h08, 8'h5A});
    check_writes("len_max", '{8'h5A}, 0);
    check_flags("len_max", 5'b10000);
  endtask

  task automatic test_frame_errors();
    apply_reset();
    send_bytes('{8'h04, 8'h00, 8'h13});
    send_byte(8'h02, 1'b0);
    check_writes("frame", '{8'h13}, 0);
    check_flags("frame", 5'b10100);
    // Loader is back at the header: a whole new frame loads from addr 0.
    wr_log.delete();
    send_bytes('{8'h04, 8'h00, 8'h13, 8'h02, 8'h80, 8'h02, 8'h93});
    check_writes("frame_retry", '{8'h13, 8'h02, 8'h80, 8'h02}, 0);
    check_flags("frame_retry", 5'b01000);
    // Short low glitch on an idle line must produce nothing.
    apply_reset();
    uart_rx = 1'b0;
    repeat (4) @(posedge clk);
    #1 uart_rx = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check_writes("glitch", '{}, 0);
    check_flags("glitch", 5'b10000);
    send_bytes('{8'h01, 8'h00, 8'hC3, 8'hC3});
    check_writes("glitch_after", '{8'hC3}, 0);
    check_flags("glitch_after", 5'b01000);
  endtask

  task automatic test_mid_reset();
    apply_reset();
    send_bytes('{8'h04, 8'h00, 8'h13, 8'h02});
    check_writes("mid", '{8'h13, 8'h02}, 0);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({wr_en, wr_addr, wr_data} !== '0) begin
      errors++;
      $display("FAIL mid_reset_wr got=%b/%h/%h exp=0/0/0", wr_en, wr_addr, wr_data);
    end
    check_flags("mid_reset", 5'b10000);
    @(posedge clk);
    #1 reset = 1'b0;
    wr_log.delete();
    send_bytes('{8'h04, 8'h00, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'h04});
    check_writes("mid_fresh", '{8'hA1, 8'hB2, 8'hC3, 8'hD4}, 0);
    check_flags("mid_fresh", 5'b01000);
  endtask

  task automatic test_post_done();
    // Continues from the completed load of the previous task.
    wr_log.delete();
    send_bytes('{8'h02, 8'h00, 8'h11, 8'h22, 8'h33});
    send_byte(8'h55, 1'b0);
    check_writes("post_done", '{}, 0);
    check_flags("post_done", 5'b01000);
  endtask

  initial begin
    test_reset();
    test_good_load();
    test_csum_mismatch();
    test_length_limits();
    test_frame_errors();
    test_mid_reset();
    test_post_done();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
